exec_result_pipe: RTL
=====================

Name: exec_result_pipe

Overview:
- Parametrised in-order result tracking and forwarding pipeline for the execute stage; successor to the fixed three-stage data_1/data_2/data_3 chain with its hard-coded wait bits.
- Holds up to DEPTH in-flight results in a circular buffer. Results arrive either at issue (single-cycle ALU ops) or later via a tagged completion port (FPU, memory, UART).
- Forwards the youngest matching result to two source operands and raises a stall when that result is still pending.
- Retires entries strictly in order to one register-file write-back port.

Parameters:
XLEN, 32, data width
DEPTH, 4, in-flight entries; power of two, 2..16
REGBITS, 5, register index width
TAGBITS, 2, entry tag width; equals log2(DEPTH)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
issue_valid  in  1  issue request
issue_accept  out  1  combinational; equals ~full
issue_tag  out  TAGBITS  combinational; tail pointer, the tag given to the issuing entry
issue_wen  in  1  entry writes a register
issue_fmode  in  1  0 = integer file, 1 = float file
issue_rd  in  REGBITS  destination register
issue_done  in  1  result available at issue
issue_data  in  XLEN  result, used when issue_done=1
cmpl_valid  in  1  completion strobe
cmpl_tag  in  TAGBITS  completing entry
cmpl_data  in  XLEN  completion result
src1_fmode, src2_fmode  in  1  source register file
src1_no, src2_no  in  REGBITS  source index
src1_regval, src2_regval  in  XLEN  register-file read value
src1_data, src2_data  out  XLEN  forwarded operand (combinational)
src_stall  out  1  either source hits a pending entry (combinational)
wb_en  out  1  register write strobe (registered)
wb_fmode  out  1  write-back file select
wb_rd  out  REGBITS  write-back index
wb_data  out  XLEN  write-back data
empty  out  1  no valid entries
cmpl_err  out  1  sticky: completion to invalid or already-ready entry

Behaviour:
- Reset (async, rstn=0): head=tail=0, count=0, all entry valid/ready bits=0. Outputs: wb_en=0, wb_fmode=0, wb_rd=0, wb_data=0, cmpl_err=0, empty=1. A reset mid-operation discards all entries; later completions to those tags set cmpl_err.
- Entry fields: valid, ready, wen, fmode, rd, data.
- Issue: accepted when issue_valid & ~full, where full means count==DEPTH, evaluated on the registered count. A same-cycle retire does not free a slot for that cycle's issue. The accepted entry is written at tail with ready=issue_done and data=issue_data. Tail wraps modulo DEPTH.
- Completion: cmpl_valid to an entry that is valid and not ready sets ready=1 and stores data at the edge. A completion to an invalid or ready entry is ignored and sets cmpl_err, which only clears on reset.
- Retire: when head is valid & ready, at the edge:
  - wb_en<=wen, wb_fmode, wb_rd, wb_data<=entry fields;
  - the entry is cleared and head advances.
  - Otherwise wb_en<=0 and the other wb_* fields hold.
  - At most one retire per cycle.
  - Entries with wen=0 still occupy a retire cycle with wb_en=0.
- Count: +1 on issue, -1 on retire, unchanged when both occur.
- Forward match for source s (src_fmode, src_no): entry valid & wen & fmode==src_fmode & rd==src_no & (fmode | rd!=0).
  - Priority: the youngest matching entry (closest to tail), then the registered wb stage when wb_en matches under the same rule, then regval.
  - If the youngest match is not ready, src_stall=1 and src_data=regval; the value is don't-care and the issuer must hold.
  - Integer register 0 never forwards and never stalls.
- Issue and source lookup in the same cycle: lookup uses pre-edge state only. The issuing entry is not visible to its own sources.
- Simultaneous completion to the head and retire: the head retires on the following cycle (without the optional bypass).

Optional Feature:
- Macro EXEC_RESULT_PIPE_BYPASS_EN.
- Defined:
  - cmpl_data is forwarded combinationally to sources whose youngest match is the completing entry; src_stall is not raised for that entry.
  - A completion to the head retires in the same cycle, so wb_* carries cmpl_data at the next edge.
- Undefined: completion data becomes visible to sources and retire one cycle after the completion edge.

Test Plan:
- Reset then issue rd=3 int, issue_done=1, data=0x11 -> src1_no=3 reads 0x11, src_stall=0; next cycle wb_en=1, wb_rd=3, wb_data=0x11; empty=1 after.
- Issue fmode=1 rd=2 pending (tag 0), then src2 float 2 -> src_stall=1; cmpl tag0 data=0x3F800000 -> stall drops the next cycle (same cycle with BYPASS_EN), src2_data=0x3F800000.
- Issue 4 pending entries -> issue_accept=0, count stays 4; a 5th issue_valid is dropped; complete tag 0 -> retire, then issue_accept=1 and the next issue_tag=0 (wrap).
- Two entries with rd=5 int (data 0xA then 0xB) -> src1_no=5 gives 0xB; integer rd=0 entries -> src_data=regval, no stall.
- Complete tags out of order (2, 1, 0) -> wb order stays 0, 1, 2 on consecutive cycles after tag 0 completes.
- cmpl_valid to an empty tag -> cmpl_err=1, state unchanged; assert rstn=0 mid-flight -> all outputs at reset values immediately.

Source files
------------

// File: rtl/exec_result_pipe.sv
// exec_result_pipe: in-order result tracking / forwarding buffer for the execute stage.
// Up to DEPTH in-flight results live in a circular buffer. They either arrive at issue
// or later through the tagged completion port, and retire in order to one write-back port.
// Optional build macro EXEC_RESULT_PIPE_BYPASS_EN: completion data is forwarded and can
// retire in the same cycle it arrives. When the macro is undefined, completion data
// becomes visible one cycle after the completion edge.
module exec_result_pipe #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 4,
   parameter int REGBITS = 5,
   parameter int TAGBITS = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               issue_valid,
   output logic               issue_accept,
   output logic [TAGBITS-1:0] issue_tag,
   input  logic               issue_wen,
   input  logic               issue_fmode,
   input  logic [REGBITS-1:0] issue_rd,
   input  logic               issue_done,
   input  logic [XLEN-1:0]    issue_data,
   input  logic               cmpl_valid,
   input  logic [TAGBITS-1:0] cmpl_tag,
   input  logic [XLEN-1:0]    cmpl_data,
   input  logic               src1_fmode,
   input  logic               src2_fmode,
   input  logic [REGBITS-1:0] src1_no,
   input  logic [REGBITS-1:0] src2_no,
   input  logic [XLEN-1:0]    src1_regval,
   input  logic [XLEN-1:0]    src2_regval,
   output logic [XLEN-1:0]    src1_data,
   output logic [XLEN-1:0]    src2_data,
   output logic               src_stall,
   output logic               wb_en,
   output logic               wb_fmode,
   output logic [REGBITS-1:0] wb_rd,
   output logic [XLEN-1:0]    wb_data,
   output logic               empty,
   output logic               cmpl_err
);

   // Entry storage
   logic [DEPTH-1:0]   r_valid;
   logic [DEPTH-1:0]   r_ready;
   logic [DEPTH-1:0]   r_wen;
   logic [DEPTH-1:0]   r_fmode;
   logic [REGBITS-1:0] r_rd   [DEPTH];
   logic [XLEN-1:0]    r_data [DEPTH];
   logic [TAGBITS-1:0] r_head;
   logic [TAGBITS-1:0] r_tail;
   logic [TAGBITS:0]   r_count;

   // Write-back stage
   logic               r_wb_en;
   logic               r_wb_fmode;
   logic [REGBITS-1:0] r_wb_rd;
   logic [XLEN-1:0]    r_wb_data;
   logic               r_cmpl_err;

   logic               w_bypass;
   logic               w_full;
   logic               w_issue;
   logic               w_cmpl_ok;
   logic               w_cmpl_head;
   logic               w_retire;

`ifdef EXEC_RESULT_PIPE_BYPASS_EN
   assign w_bypass = 1'b1;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_full       = (r_count == (TAGBITS+1)'(DEPTH));
   assign w_issue      = issue_valid & ~w_full;
   assign w_cmpl_ok    = cmpl_valid & r_valid[cmpl_tag] & ~r_ready[cmpl_tag];
   assign w_cmpl_head  = w_bypass & w_cmpl_ok & (cmpl_tag == r_head);
   assign w_retire     = r_valid[r_head] & (r_ready[r_head] | w_cmpl_head);

   assign issue_accept = ~w_full;
   assign issue_tag    = r_tail;
   assign empty        = (r_count == '0);
   assign wb_en        = r_wb_en;
   assign wb_fmode     = r_wb_fmode;
   assign wb_rd        = r_wb_rd;
   assign wb_data      = r_wb_data;
   assign cmpl_err     = r_cmpl_err;

   // Per-source lookup; index 0 is src1, index 1 is src2
   logic [1:0]         w_src_fmode;
   logic [REGBITS-1:0] w_src_no     [2];
   logic [XLEN-1:0]    w_src_regval [2];
   logic [XLEN-1:0]    w_src_data   [2];
   logic [1:0]         w_src_stall;

   assign w_src_fmode     = {src2_fmode, src1_fmode};
   assign w_src_no[0]     = src1_no;
   assign w_src_no[1]     = src2_no;
   assign w_src_regval[0] = src1_regval;
   assign w_src_regval[1] = src2_regval;
   assign src1_data       = w_src_data[0];
   assign src2_data       = w_src_data[1];
   assign src_stall       = |w_src_stall;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic               w_hit;
         logic [TAGBITS-1:0] w_hit_tag;
         logic               w_wb_hit;
         logic [XLEN-1:0]    w_data;
         logic               w_stall;

         // Walk the buffer oldest to youngest so the last hit is the youngest match
         always_comb begin
            logic [TAGBITS-1:0] v_idx;
            v_idx     = r_head;
            w_hit     = 1'b0;
            w_hit_tag = '0;
            for (int k = 0; k < DEPTH; k++) begin
               v_idx = r_head + TAGBITS'(k);
               if (r_valid[v_idx] & r_wen[v_idx] & (r_fmode[v_idx] == w_src_fmode[gi]) &
                   (r_rd[v_idx] == w_src_no[gi]) & (w_src_fmode[gi] | (w_src_no[gi] != '0))) begin
                  w_hit     = 1'b1;
                  w_hit_tag = v_idx;
               end
            end
         end

         // Select operand: youngest entry, then the write-back stage, then the register file
         always_comb begin
            w_wb_hit = r_wb_en & (r_wb_fmode == w_src_fmode[gi]) & (r_wb_rd == w_src_no[gi]) &
                       (w_src_fmode[gi] | (w_src_no[gi] != '0));
            w_data   = w_src_regval[gi];
            w_stall  = 1'b0;
            if (w_hit) begin
               if (r_ready[w_hit_tag]) begin
                  w_data = r_data[w_hit_tag];
               end else if (w_bypass & w_cmpl_ok & (cmpl_tag == w_hit_tag)) begin
                  w_data = cmpl_data;
               end else begin
                  w_stall = 1'b1;
               end
            end else if (w_wb_hit) begin
               w_data = r_wb_data;
            end
         end

         assign w_src_data[gi]  = w_data;
         assign w_src_stall[gi] = w_stall;
      end
   endgenerate

   // Buffer state: completion, in-order retire, issue at tail, occupancy, sticky error
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid    <= '0;
         r_ready    <= '0;
         r_wen      <= '0;
         r_fmode    <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_rd[k]   <= '0;
            r_data[k] <= '0;
         end
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_wb_en    <= 1'b0;
         r_wb_fmode <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_cmpl_err <= 1'b0;
      end else begin
         if (w_cmpl_ok) begin
            r_ready[cmpl_tag] <= 1'b1;
            r_data[cmpl_tag]  <= cmpl_data;
         end
         if (cmpl_valid & ~w_cmpl_ok) begin
            r_cmpl_err <= 1'b1;
         end
         if (w_retire) begin
            r_wb_en         <= r_wen[r_head];
            r_wb_fmode      <= r_fmode[r_head];
            r_wb_rd         <= r_rd[r_head];
            r_wb_data       <= w_cmpl_head ? cmpl_data : r_data[r_head];
            r_valid[r_head] <= 1'b0;
            r_ready[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end else begin
            r_wb_en <= 1'b0;
         end
         // Tail slot is never the retiring head: they coincide only when empty or full
         if (w_issue) begin
            r_valid[r_tail] <= 1'b1;
            r_ready[r_tail] <= issue_done;
            r_wen[r_tail]   <= issue_wen;
            r_fmode[r_tail] <= issue_fmode;
            r_rd[r_tail]    <= issue_rd;
            r_data[r_tail]  <= issue_data;
            r_tail          <= r_tail + 1'b1;
         end
         if (w_issue & ~w_retire) begin
            r_count <= r_count + 1'b1;
         end else if (~w_issue & w_retire) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
